dmem_access_unit: RTL and testbench

- Memory-access stage directly downstream of the ALU in the single-cycle MIPS core.
- Takes the ALU result as the byte address, plus store data and the mem_read/mem_write controls.
- Runs one word access on an external data memory using a cen/ready handshake.
- Holds the core with stall until the access completes, then returns load data; flags misaligned addresses and memory timeouts.

---
 rtl/dmem_access_unit_pkg.sv | 15 +
 rtl/dmem_access_unit_if.sv | 24 ++
 rtl/dmem_access_unit.sv | 110 +++++++++++
 tb/tb_dmem_access_unit.sv | 214 +++++++++++++++++++++
 4 files changed

// File: rtl/dmem_access_unit_pkg.sv
// Shared definitions for the data-memory access stage: FSM state encoding and
// default widths/limits used by the interface and the unit itself.
package dmem_pkg;

  localparam int DMEM_DATA_W         = 32;
  localparam int DMEM_TIMEOUT_CYCLES = 255;
  localparam int DMEM_CNT_W          = 8;

  typedef enum logic [1:0] {
    IDLE,
    ACCESS,
    DONE
  } state_t;

endpackage

// File: rtl/dmem_access_unit_if.sv
// External data-memory bus: cen/ready handshake carrying one word access.
// The access unit is the master; the memory model or SRAM wrapper is the slave.
interface dmem_access_unit_if #(
  parameter int DATA_W = dmem_pkg::DMEM_DATA_W
);

  logic              mem_cen;
  logic              mem_wen;
  logic [DATA_W-3:0] mem_addr;
  logic [DATA_W-1:0] mem_wdata;
  logic [DATA_W-1:0] mem_rdata;
  logic              mem_ready;

  modport master (
    output mem_cen, mem_wen, mem_addr, mem_wdata,
    input  mem_rdata, mem_ready
  );

  modport slave (
    input  mem_cen, mem_wen, mem_addr, mem_wdata,
    output mem_rdata, mem_ready
  );

endinterface

// File: rtl/dmem_access_unit.sv
// Memory-access stage of the single-cycle core: issues one word access per
// request on the cen/ready bus, stalls the core until completion or timeout.
module dmem_access_unit
  import dmem_pkg::*;
#(
  parameter int DATA_W         = DMEM_DATA_W,
  parameter int TIMEOUT_CYCLES = DMEM_TIMEOUT_CYCLES,
  parameter int CNT_W          = DMEM_CNT_W
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [DATA_W-1:0] alu_result,
  input  logic [DATA_W-1:0] store_data,
  input  logic              mem_read,
  input  logic              mem_write,
  output logic              stall,
  output logic [DATA_W-1:0] load_data,
  output logic              done,
  output logic              addr_err,
  output logic              bus_err,
  dmem_access_unit_if.master mem
);

  state_t            state_q;
  logic [CNT_W-1:0]  count_q;
  logic [CNT_W-1:0]  count_d;
  logic              cen_q;
  logic              wen_q;
  logic [DATA_W-3:0] addr_q;
  logic [DATA_W-1:0] wdata_q;
  logic [DATA_W-1:0] load_data_q;
  logic              done_q;
  logic              bus_err_q;

  logic req;
  logic illegal;
  logic timeout;

  assign req     = mem_read | mem_write;
  assign illegal = (mem_read & mem_write) | (req & (alu_result[1:0] != 2'b00));
  assign count_d = count_q + CNT_W'(1);
  assign timeout = (count_q == CNT_W'(TIMEOUT_CYCLES - 1));

  // Combinational so the core is held in the very cycle it raises a request.
  assign stall    = ((state_q == IDLE) && req && !illegal) || (state_q == ACCESS);
  assign addr_err = (state_q == IDLE) && illegal;

  // NOTE: every register here, datapath included, is cleared on reset so a
  // post-reset core never sees stale load data or a phantom write strobe.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      count_q     <= '0;
      cen_q       <= 1'b0;
      wen_q       <= 1'b0;
      addr_q      <= '0;
      wdata_q     <= '0;
      load_data_q <= '0;
      done_q      <= 1'b0;
      bus_err_q   <= 1'b0;
    end else begin
      unique case (state_q)
        IDLE: begin
          if (req && !illegal) begin
            addr_q  <= alu_result[DATA_W-1:2];
            wdata_q <= store_data;
            wen_q   <= mem_write;
            cen_q   <= 1'b1;
            count_q <= '0;
            state_q <= ACCESS;
          end
        end
        ACCESS: begin
          // Ready wins over a timeout landing in the same cycle.
          if (mem.mem_ready) begin
            load_data_q <= wen_q ? '0 : mem.mem_rdata;
            bus_err_q   <= 1'b0;
            cen_q       <= 1'b0;
            done_q      <= 1'b1;
            state_q     <= DONE;
          end else if (timeout) begin
            load_data_q <= '0;
            bus_err_q   <= 1'b1;
            cen_q       <= 1'b0;
            done_q      <= 1'b1;
            state_q     <= DONE;
          end else begin
            count_q <= count_d;
          end
        end
        DONE: begin
          done_q    <= 1'b0;
          bus_err_q <= 1'b0;
          state_q   <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign mem.mem_cen   = cen_q;
  assign mem.mem_wen   = wen_q;
  assign mem.mem_addr  = addr_q;
  assign mem.mem_wdata = wdata_q;

  assign load_data = load_data_q;
  assign done      = done_q;
  assign bus_err   = bus_err_q;

endmodule

// File: tb/tb_dmem_access_unit.sv
// Self-checking bench for dmem_access_unit: directed scenarios plus randomized
// transactions predicted by a transaction-level model of stall/done/result.
module tb_dmem_access_unit;

  localparam int DW = 32;
  localparam int T  = 4;

  logic          clk = 1'b0;
  logic          rst;
  logic [DW-1:0] alu_result;
  logic [DW-1:0] store_data;
  logic          mem_read;
  logic          mem_write;
  logic          stall;
  logic [DW-1:0] load_data;
  logic          done;
  logic          addr_err;
  logic          bus_err;

  int checks = 0;
  int errors = 0;

  dmem_access_unit_if #(.DATA_W(DW)) mem_bus ();

  dmem_access_unit #(
    .DATA_W(DW),
    .TIMEOUT_CYCLES(T),
    .CNT_W(8)
  ) dut (
    .clk(clk),
    .rst(rst),
    .alu_result(alu_result),
    .store_data(store_data),
    .mem_read(mem_read),
    .mem_write(mem_write),
    .stall(stall),
    .load_data(load_data),
    .done(done),
    .addr_err(addr_err),
    .bus_err(bus_err),
    .mem(mem_bus)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [DW-1:0] got, input logic [DW-1:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  // One core request; k is the ACCESS cycle in which the memory answers (0 = never).
  task automatic do_access(input logic rd, input logic wr, input logic [DW-1:0] addr,
                           input logic [DW-1:0] wdata, input logic [DW-1:0] rdata,
                           input int k);
    logic          illegal_e;
    logic          bus_e;
    int            acc_e;
    logic [DW-1:0] load_e;
    int            stall_n;
    int            acc;

    illegal_e = (rd && wr) || ((rd || wr) && (addr[1:0] != 2'b00));
    bus_e     = !(k >= 1 && k <= T);
    acc_e     = bus_e ? T : k;
    load_e    = (wr || bus_e) ? '0 : rdata;

    @(posedge clk); #1;
    alu_result         = addr;
    store_data         = wdata;
    mem_read           = rd;
    mem_write          = wr;
    mem_bus.mem_ready  = 1'b0;
    @(negedge clk);

    if (illegal_e) begin
      check("illegal_addr_err", {31'b0, addr_err}, 32'd1);
      check("illegal_stall", {31'b0, stall}, 32'd0);
      @(negedge clk);
      check("illegal_cen", {31'b0, mem_bus.mem_cen}, 32'd0);
      check("illegal_done", {31'b0, done}, 32'd0);
      @(posedge clk); #1;
      mem_read  = 1'b0;
      mem_write = 1'b0;
      return;
    end

    check("req_stall", {31'b0, stall}, 32'd1);
    check("req_addr_err", {31'b0, addr_err}, 32'd0);
    check("req_cen", {31'b0, mem_bus.mem_cen}, 32'd0);

    stall_n = 1;
    acc     = 0;
    while (1) begin
      @(posedge clk); #1;
      if (mem_bus.mem_cen) begin
        acc++;
        mem_bus.mem_ready = (acc == k);
        mem_bus.mem_rdata = (acc == k) ? rdata : $urandom;
      end else begin
        mem_bus.mem_ready = 1'b0;
      end
      @(negedge clk);
      if (!stall) break;
      stall_n++;
      if (stall_n == 2) begin
        check("acc_cen", {31'b0, mem_bus.mem_cen}, 32'd1);
        check("acc_addr", {2'b00, mem_bus.mem_addr}, addr >> 2);
        check("acc_wen", {31'b0, mem_bus.mem_wen}, {31'b0, wr});
        check("acc_wdata", mem_bus.mem_wdata, wdata);
      end
      if (stall_n > T + 3) break;
    end

    check("stall_cycles", stall_n, acc_e + 1);
    check("done_pulse", {31'b0, done}, 32'd1);
    check("done_bus_err", {31'b0, bus_err}, {31'b0, bus_e});
    check("done_load_data", load_data, load_e);
    check("done_cen", {31'b0, mem_bus.mem_cen}, 32'd0);

    @(posedge clk); #1;
    mem_read          = 1'b0;
    mem_write         = 1'b0;
    mem_bus.mem_ready = 1'b0;
    @(negedge clk);
    check("idle_done", {31'b0, done}, 32'd0);
    check("idle_bus_err", {31'b0, bus_err}, 32'd0);
    check("idle_load_hold", load_data, load_e);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic          rd;
    logic          wr;
    logic [DW-1:0] addr;
    int            sel;

    rst               = 1'b1;
    alu_result        = '0;
    store_data        = '0;
    mem_read          = 1'b0;
    mem_write         = 1'b0;
    mem_bus.mem_ready = 1'b0;
    mem_bus.mem_rdata = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_stall", {31'b0, stall}, 32'd0);
    check("rst_done", {31'b0, done}, 32'd0);
    check("rst_bus_err", {31'b0, bus_err}, 32'd0);
    check("rst_addr_err", {31'b0, addr_err}, 32'd0);
    check("rst_load_data", load_data, 32'd0);
    check("rst_cen", {31'b0, mem_bus.mem_cen}, 32'd0);
    check("rst_wen", {31'b0, mem_bus.mem_wen}, 32'd0);
    check("rst_addr", {2'b00, mem_bus.mem_addr}, 32'd0);
    check("rst_wdata", mem_bus.mem_wdata, 32'd0);
    @(posedge clk); #1;
    rst = 1'b0;

    // Directed scenarios.
    do_access(1'b1, 1'b0, 32'h0000_0010, 32'h0000_0000, 32'hDEAD_BEEF, 3);
    do_access(1'b0, 1'b1, 32'h0000_0020, 32'h1234_5678, 32'hFFFF_FFFF, 1);
    do_access(1'b1, 1'b0, 32'h0000_0013, 32'h0000_0000, 32'h0000_0000, 1);
    do_access(1'b1, 1'b1, 32'h0000_0040, 32'h0000_0000, 32'h0000_0000, 1);
    do_access(1'b1, 1'b0, 32'h0000_0080, 32'h0000_0000, 32'hCAFE_F00D, 0);
    do_access(1'b1, 1'b0, 32'h0000_0084, 32'h0000_0000, 32'h0BAD_F00D, T);

    // Reset in the second ACCESS cycle, then a late ready that must be ignored.
    @(posedge clk); #1;
    alu_result = 32'h0000_0100;
    mem_read   = 1'b1;
    @(posedge clk); #1;
    @(posedge clk); #1;
    rst      = 1'b1;
    mem_read = 1'b0;
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    check("mid_rst_cen", {31'b0, mem_bus.mem_cen}, 32'd0);
    check("mid_rst_stall", {31'b0, stall}, 32'd0);
    check("mid_rst_done", {31'b0, done}, 32'd0);
    @(posedge clk); #1;
    mem_bus.mem_ready = 1'b1;
    mem_bus.mem_rdata = 32'hA5A5_A5A5;
    @(negedge clk);
    check("late_ready_done0", {31'b0, done}, 32'd0);
    @(posedge clk); #1;
    mem_bus.mem_ready = 1'b0;
    @(negedge clk);
    check("late_ready_done1", {31'b0, done}, 32'd0);
    check("late_ready_load", load_data, 32'd0);
    check("late_ready_cen", {31'b0, mem_bus.mem_cen}, 32'd0);

    // Randomized transactions.
    for (int n = 0; n < 40; n++) begin
      sel  = $urandom_range(0, 9);
      rd   = (sel <= 4) || (sel == 9);
      wr   = (sel >= 5);
      addr = $urandom;
      if ($urandom_range(0, 4) != 0) addr[1:0] = 2'b00;
      do_access(rd, wr, addr, $urandom, $urandom, $urandom_range(0, T + 2));
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
